// File: rtl/edp_diag_port.sv
// EBOX diagnostic access sequencer: AR deposit via override, data-path examine via EBUS diag read.
// Optional EBUS/response odd parity when EDP_DIAG_PARITY_EN is defined.
module edp_diag_port #(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_sel,
    input  logic [0:35] cmd_data,
    output logic        overrideAR,
    output logic [0:35] ARvalue,
    input  logic        ebus_grant,
    output logic        diag_read,
    output logic [2:0]  diag_sel,
    input  logic [0:35] ebus_data,
`ifdef EDP_DIAG_PARITY_EN
    input  logic        ebus_par,
    output logic        rsp_par,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:35] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, DEP, EX_REQ, EX_DRV, RESP} state_t;

    localparam logic [1:0] OP_DEP = 2'b00;
    localparam logic [1:0] OP_EX  = 2'b01;
    localparam logic [1:0] OP_VFY = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  sel_q, sel_d;
    logic [0:35] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        override_q, override_d;
    logic [0:35] arvalue_q, arvalue_d;
    logic        diag_read_q, diag_read_d;
    logic [2:0]  diag_sel_q, diag_sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [0:35] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;
    logic        par_err;

`ifdef EDP_DIAG_PARITY_EN
    logic        rsp_par_q, rsp_par_d;
    assign par_err = ~(^{ebus_data, ebus_par});
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sel_d      = sel_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = cmd_op;
                    // verify always reads back AR
                    sel_d  = (cmd_op == OP_VFY) ? 3'd0 : cmd_sel;
                    data_d = cmd_data;
                    cnt_d  = 8'd0;
                    case (cmd_op)
                        OP_DEP, OP_VFY: state_d = DEP;
                        OP_EX:          state_d = EX_REQ;
                        default: begin
                            state_d    = RESP;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            DEP: begin
                if (op_q == OP_DEP) begin
                    state_d    = RESP;
                    rsp_data_d = data_q;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = EX_REQ;
                    cnt_d   = 8'd0;
                end
            end
            EX_REQ: begin
                if (ebus_grant) begin
                    state_d = EX_DRV;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    state_d    = RESP;
                    cnt_d      = 8'd0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EX_DRV: begin
                // grant is not rechecked here; the data path owns EBUS until capture
                if (cnt_q == 8'(SETTLE_CYC - 1)) begin
                    state_d    = RESP;
                    cnt_d      = 8'd0;
                    rsp_data_d = ebus_data;
                    rsp_err_d  = ((op_q == OP_VFY) && (ebus_data != data_q)) || par_err;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        override_d  = (state_d == DEP);
        arvalue_d   = (state_d == DEP) ? data_d : '0;
        diag_read_d = (state_d == EX_DRV);
        diag_sel_d  = (state_d == EX_DRV) ? sel_d : 3'd0;
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

`ifdef EDP_DIAG_PARITY_EN
    assign rsp_par_d = (state_d == RESP) ? ~(^rsp_data_d) : 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            sel_q       <= 3'd0;
            data_q      <= '0;
            cnt_q       <= 8'd0;
            cmd_ready_q <= 1'b1;
            override_q  <= 1'b0;
            arvalue_q   <= '0;
            diag_read_q <= 1'b0;
            diag_sel_q  <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef EDP_DIAG_PARITY_EN
            rsp_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            override_q  <= override_d;
            arvalue_q   <= arvalue_d;
            diag_read_q <= diag_read_d;
            diag_sel_q  <= diag_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
`ifdef EDP_DIAG_PARITY_EN
            rsp_par_q   <= rsp_par_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign overrideAR = override_q;
    assign ARvalue    = arvalue_q;
    assign diag_read  = diag_read_q;
    assign diag_sel   = diag_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
`ifdef EDP_DIAG_PARITY_EN
    assign rsp_par    = rsp_par_q;
`endif

endmodule

// File: tb/tb_edp_diag_port.sv
// Scoreboard bench for edp_diag_port: driver pushes expected responses, monitor pops and checks.
module tb_edp_diag_port;
    localparam int S = 2;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_sel = 3'd0;
    logic [0:35] cmd_data = '0;
    logic        overrideAR;
    logic [0:35] ARvalue;
    logic        ebus_grant = 1'b0;
    logic        diag_read;
    logic [2:0]  diag_sel;
    logic [0:35] ebus_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [0:35] rsp_data;
    logic        rsp_err;
    logic        busy;
`ifdef EDP_DIAG_PARITY_EN
    logic        ebus_par = 1'b1;
    logic        rsp_par;
`endif

    edp_diag_port #(.SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_data(cmd_data),
        .overrideAR(overrideAR), .ARvalue(ARvalue),
        .ebus_grant(ebus_grant), .diag_read(diag_read), .diag_sel(diag_sel),
        .ebus_data(ebus_data),
`ifdef EDP_DIAG_PARITY_EN
        .ebus_par(ebus_par), .rsp_par(rsp_par),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:35] data;
        logic        err;
        int          lat;
        int          n_ovr;
        int          n_drd;
        logic [2:0]  sel;
        logic [0:35] dep;
        int          acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference response for one command, from the behavioural rules only.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] sel,
                                   input logic [0:35] dep, input logic [0:35] ev, input int d);
        exp_t e;
        e.dep = dep; e.sel = 3'd0; e.n_ovr = 0; e.n_drd = 0; e.acc = 0;
        e.data = '0; e.err = 1'b1; e.lat = 1;
        case (op)
            2'b00: begin e.data = dep; e.err = 1'b0; e.lat = 2; e.n_ovr = 1; end
            2'b01: begin
                if (d < 0) e.lat = 1 + T;
                else begin e.data = ev; e.err = 1'b0; e.lat = 2 + d + S; e.n_drd = S; e.sel = sel; end
            end
            2'b10: begin
                e.n_ovr = 1;
                if (d < 0) e.lat = 2 + T;
                else begin e.data = ev; e.err = (ev != dep); e.lat = 3 + d + S; e.n_drd = S; end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (!cmd_ready) chk("cmd_ready_wait", 36'(cmd_ready), 36'd1);
    endtask

    // d: grant delay in cycles after EX_REQ is entered (-1 = never); h: cycles rsp_ready is withheld
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [0:35] dep,
                           input logic [0:35] ev, input int d, input int h);
        exp_t e;
        int k, nv, start;
        bit done;
        wait_ready();
        e = model(op, sel, dep, ev, d);
        e.acc = cyc;
        q.push_back(e);
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_data = dep;
        ebus_data = ev; ebus_grant = 1'b0;
`ifdef EDP_DIAG_PARITY_EN
        ebus_par = ~(^ev);
`endif
        start = (op == 2'b10) ? 2 : 1;
        k = 0; nv = 0; done = 1'b0;
        while (!done && k < 600) begin
            @(posedge clk); #1; k++;
            cmd_valid = 1'b0;
            if (d < 0 || k < start + d) ebus_grant = 1'b0;
            else if (k == start + d)    ebus_grant = 1'b1;
            else                        ebus_grant = 1'($urandom_range(0, 1));
            if (rsp_ready) begin
                rsp_ready = 1'b0;
                done = 1'b1;
            end else if (rsp_valid) begin
                nv++;
                if (nv > h) rsp_ready = 1'b1;
            end
        end
        ebus_grant = 1'b0;
        if (!done) chk("rsp_timeout", 36'(done), 36'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cmd_ready"}, 36'(cmd_ready), 36'd1);
        chk({tag, "_overrideAR"}, 36'(overrideAR), 36'd0);
        chk({tag, "_ARvalue"}, ARvalue, 36'd0);
        chk({tag, "_diag_read"}, 36'(diag_read), 36'd0);
        chk({tag, "_diag_sel"}, 36'(diag_sel), 36'd0);
        chk({tag, "_rsp_valid"}, 36'(rsp_valid), 36'd0);
        chk({tag, "_rsp_data"}, rsp_data, 36'd0);
        chk({tag, "_rsp_err"}, 36'(rsp_err), 36'd0);
        chk({tag, "_busy"}, 36'(busy), 36'd0);
    endtask

    // Monitor
    initial begin
        int n_ovr = 0;
        int n_drd = 0;
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_ovr = 0; n_drd = 0; seen = 1'b0;
            end else begin
                chk("ovr_drd_exclusive", 36'(overrideAR && diag_read), 36'd0);
                if (!overrideAR) chk("ARvalue_zero", ARvalue, 36'd0);
                if (overrideAR) begin
                    n_ovr++;
                    if (q.size() > 0) chk("ARvalue", ARvalue, q[0].dep);
                end
                if (diag_read) begin
                    n_drd++;
                    if (q.size() > 0) chk("diag_sel", 36'(diag_sel), 36'(q[0].sel));
                end
                if (rsp_valid) begin
                    if (q.size() == 0) chk("unexpected_rsp", 36'(rsp_valid), 36'd0);
                    else begin
                        if (!seen) begin
                            seen = 1'b1;
                            chk("latency", 36'(cyc - q[0].acc), 36'(q[0].lat));
                            chk("override_cycles", 36'(n_ovr), 36'(q[0].n_ovr));
                            chk("diag_read_cycles", 36'(n_drd), 36'(q[0].n_drd));
                        end
                        chk("rsp_data", rsp_data, q[0].data);
                        chk("rsp_err", 36'(rsp_err), 36'(q[0].err));
                        chk("cmd_ready_in_rsp", 36'(cmd_ready), 36'd0);
                        chk("busy_in_rsp", 36'(busy), 36'd1);
                        if (rsp_ready) begin
                            void'(q.pop_front());
                            seen = 1'b0; n_ovr = 0; n_drd = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        logic [63:0] r;
        logic [0:35] dep, ev;
        logic [1:0]  op;
        int          d, k;

        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_cmd(2'b00, 3'd0, 36'o123456701234, 36'o0, 0, 0);
        run_cmd(2'b01, 3'd3, 36'o0, 36'o777000000777, 0, 0);
        run_cmd(2'b10, 3'd5, 36'o1, 36'o2, 0, 0);
        run_cmd(2'b10, 3'd6, 36'o1, 36'o1, 0, 0);
        run_cmd(2'b01, 3'd4, 36'o0, 36'o555, -1, 0);
        run_cmd(2'b11, 3'd2, 36'o777, 36'o0, 0, 5);
        run_cmd(2'b01, 3'd7, 36'o0, 36'o404040404040, T - 1, 1);

        // Reset in the middle of a diag read
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 3'd5; ebus_grant = 1'b1;
        ebus_data = 36'o111111111111;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!diag_read && k < 20) begin @(posedge clk); #1; k++; end
        chk("reach_ex_drv", 36'(diag_read), 36'd1);
        #2 reset = 1'b1;
        #1 chk_idle("midreset");
        ebus_grant = 1'b0;
        q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        run_cmd(2'b01, 3'd1, 36'o0, 36'o246024602460, 0, 0);

        for (int i = 0; i < 40; i++) begin
            r = {$urandom(), $urandom()};
            dep = r[35:0];
            r = {$urandom(), $urandom()};
            ev = r[35:0];
            op = 2'($urandom_range(0, 3));
            if (op == 2'b10 && $urandom_range(0, 1) == 1) ev = dep;
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T - 1));
            run_cmd(op, 3'($urandom_range(0, 7)), dep, ev, d, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 36'(q.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
